// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ byte-stream
// requesters; a grant lasts one message (req_last) or MAX_MSG bytes, whichever comes first.
module uart_tx_scheduler #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_MSG  = 16,
  parameter int unsigned HOLD_MAX = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       uart_data,
  output logic                    uart_start,
  input  logic                    uart_busy,
  output logic [N_REQ-1:0]        grant,
  output logic [15:0]             msg_count
);

  localparam int unsigned PTR_W       = $clog2(N_REQ);
  localparam int unsigned BCNT_W      = $clog2(MAX_MSG + 1);
  localparam int unsigned ICNT_W      = $clog2(HOLD_MAX + 1);
  localparam int unsigned ACK_TIMEOUT = 4;
  localparam int unsigned ACNT_W      = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    START     = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    gidx;
  logic [PTR_W-1:0]    nxt_ptr;
  logic [BCNT_W-1:0]   byte_cnt;
  logic [ICNT_W-1:0]   idle_cnt;
  logic [ACNT_W-1:0]   ack_cnt;
  logic                last_q;

  logic [PTR_W-1:0]    sel_idx;
  logic                sel_found;
  logic                g_valid;
  logic                g_last;
  logic [DATA_W-1:0]   g_data;

  logic do_grant;
  logic do_hs;
  logic do_release;
  logic inc_msg;
  logic idle_inc;
  logic idle_clr;
  logic ack_inc;
  logic byte_done;

  // First requesting index at or after ptr, searching upward with wrap.
  always_comb begin
    logic [PTR_W-1:0] cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = PTR_W'((32'(ptr) + k) % N_REQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    g_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gidx == PTR_W'(i)) g_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign g_valid = req_valid[gidx];
  assign g_last  = req_last[gidx];
  assign nxt_ptr = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + PTR_W'(1);

  always_comb begin
    next_state = state;
    do_grant   = 1'b0;
    do_hs      = 1'b0;
    do_release = 1'b0;
    inc_msg    = 1'b0;
    idle_inc   = 1'b0;
    idle_clr   = 1'b0;
    ack_inc    = 1'b0;
    byte_done  = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          do_grant   = 1'b1;
          next_state = SEND;
        end
      end
      SEND: begin
        if (g_valid) begin
          if (!uart_busy) begin
            do_hs      = 1'b1;
            next_state = START;
          end
        end else if (idle_cnt == ICNT_W'(HOLD_MAX - 1)) begin
          do_release = 1'b1;
          next_state = IDLE;
        end else begin
          idle_inc = 1'b1;
        end
      end
      START: next_state = WAIT_ACK;
      WAIT_ACK: begin
        // A UART that never raises busy must not lock the scheduler up.
        if (uart_busy) next_state = WAIT_DONE;
        else if (ack_cnt == ACNT_W'(ACK_TIMEOUT - 1)) byte_done = 1'b1;
        else ack_inc = 1'b1;
      end
      WAIT_DONE: begin
        if (!uart_busy) byte_done = 1'b1;
      end
      default: next_state = IDLE;
    endcase

    if (byte_done) begin
      if (last_q) begin
        inc_msg    = 1'b1;
        do_release = 1'b1;
        next_state = IDLE;
      end else if (byte_cnt == BCNT_W'(MAX_MSG)) begin
        do_release = 1'b1;
        next_state = IDLE;
      end else begin
        idle_clr   = 1'b1;
        next_state = SEND;
      end
    end
  end

  assign req_ready  = (state == SEND && !uart_busy) ? grant : '0;
  assign uart_start = (state == START);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant     <= '0;
      gidx      <= '0;
      ptr       <= '0;
      byte_cnt  <= '0;
      idle_cnt  <= '0;
      ack_cnt   <= '0;
      last_q    <= 1'b0;
      uart_data <= '0;
      msg_count <= '0;
    end else begin
      if (do_grant) begin
        grant    <= N_REQ'(1) << sel_idx;
        gidx     <= sel_idx;
        byte_cnt <= '0;
        idle_cnt <= '0;
      end
      if (do_hs) begin
        uart_data <= g_data;
        last_q    <= g_last;
        byte_cnt  <= byte_cnt + BCNT_W'(1);
        ack_cnt   <= '0;
      end
      if (idle_inc) idle_cnt <= idle_cnt + ICNT_W'(1);
      if (idle_clr) idle_cnt <= '0;
      if (ack_inc)  ack_cnt  <= ack_cnt + ACNT_W'(1);
      if (do_release) begin
        grant <= '0;
        ptr   <= nxt_ptr;
      end
      if (inc_msg) msg_count <= msg_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: byte-queue requesters, a UART busy model,
// and a log of every byte started on the UART.
module tb_uart_tx_scheduler;

  typedef struct packed {
    logic [3:0] g;
    logic [7:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_last  = '0;
  logic [3:0]  req_ready;
  logic [7:0]  uart_data;
  logic        uart_start;
  logic        uart_busy;
  logic [3:0]  grant;
  logic [15:0] msg_count;

  int   checks   = 0;
  int   errors   = 0;
  int   busy_len = 20;
  int   busy_cnt = 0;
  ent_t sent[$];
  logic [8:0] rq [4][$];
  logic [8:0] head;
  event kick;

  uart_tx_scheduler #(
    .N_REQ(4), .DATA_W(8), .MAX_MSG(4), .HOLD_MAX(8)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .uart_data(uart_data),
    .uart_start(uart_start), .uart_busy(uart_busy), .grant(grant),
    .msg_count(msg_count)
  );

  always #5 clk = ~clk;

  // UART model: busy for busy_len cycles after each start; busy_len 0 never acks.
  assign uart_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    if (uart_start && busy_len != 0) busy_cnt <= busy_len;
    else if (busy_cnt != 0)          busy_cnt <= busy_cnt - 1;
  end

  always @(posedge clk) begin
    if (uart_start) sent.push_back(ent_t'({grant, uart_data}));
    for (int i = 0; i < 4; i++)
      if (req_valid[i] && req_ready[i] && rq[i].size() != 0) void'(rq[i].pop_front());
  end

  always begin
    @(negedge clk or kick);
    for (int i = 0; i < 4; i++) begin
      if (rq[i].size() != 0) begin
        head = rq[i][0];
        req_valid[i]       = 1'b1;
        req_last[i]        = head[8];
        req_data[i*8 +: 8] = head[7:0];
      end else begin
        req_valid[i]       = 1'b0;
        req_last[i]        = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
      end
    end
  end

  task automatic apply_reset();
    for (int i = 0; i < 4; i++) rq[i].delete();
    ->kick;
    rst = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 100 && uart_busy; n++) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sent.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++; if (uart_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", uart_start); end
    checks++; if (uart_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", uart_data); end
    checks++; if (msg_count !== 16'd0) begin errors++; $display("FAIL reset_msg_count: got %0d expected 0", msg_count); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_message();
    ent_t exp_q [3];
    ent_t got;
    logic bad_grant;
    exp_q = '{ {4'b0010, 8'h41}, {4'b0010, 8'h42}, {4'b0010, 8'h43} };
    apply_reset();
    busy_len = 20;
    rq[1].push_back({1'b0, 8'h41});
    rq[1].push_back({1'b0, 8'h42});
    rq[1].push_back({1'b1, 8'h43});
    ->kick;
    @(negedge clk);
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL single_grant_t1: got %b expected 0010", grant); end
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready_t1: got %b expected 0010", req_ready); end
    @(negedge clk);
    checks++; if (uart_start !== 1'b1 || uart_data !== 8'h41) begin
      errors++; $display("FAIL single_start_h1: start=%b data=%h expected 1/41", uart_start, uart_data);
    end
    @(negedge clk);
    checks++; if (uart_start !== 1'b0) begin errors++; $display("FAIL single_start_width: got %b expected 0", uart_start); end
    for (int n = 0; n < 100 && uart_busy; n++) @(negedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready_after_busy: got %b expected 0010", req_ready); end
    bad_grant = 1'b0;
    for (int n = 0; n < 300 && msg_count !== 16'd1; n++) begin
      @(negedge clk);
      if (grant !== 4'b0000 && grant !== 4'b0010) bad_grant = 1'b1;
    end
    checks++; if (msg_count !== 16'd1) begin errors++; $display("FAIL single_msg_count: got %0d expected 1", msg_count); end
    checks++; if (bad_grant !== 1'b0) begin errors++; $display("FAIL single_foreign_grant: got %b expected 0", bad_grant); end
    checks++; if (sent.size() != 3) begin errors++; $display("FAIL single_byte_count: got %0d expected 3", sent.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < sent.size()) ? sent[i] : ent_t'(12'h0);
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL single_byte%0d: got g=%b d=%h expected g=%b d=%h", i, got.g, got.d, exp_q[i].g, exp_q[i].d); end
    end
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL single_grant_end: got %b expected 0000", grant); end
  endtask

  task automatic test_round_robin();
    ent_t exp_q [8];
    ent_t got;
    exp_q = '{ {4'b0001, 8'hA0}, {4'b0001, 8'hA1}, {4'b0100, 8'hC0}, {4'b0100, 8'hC1},
               {4'b0001, 8'hA2}, {4'b0001, 8'hA3}, {4'b0100, 8'hC2}, {4'b0100, 8'hC3} };
    apply_reset();
    busy_len = 3;
    rq[0].push_back({1'b0, 8'hA0}); rq[0].push_back({1'b1, 8'hA1});
    rq[0].push_back({1'b0, 8'hA2}); rq[0].push_back({1'b1, 8'hA3});
    rq[2].push_back({1'b0, 8'hC0}); rq[2].push_back({1'b1, 8'hC1});
    rq[2].push_back({1'b0, 8'hC2}); rq[2].push_back({1'b1, 8'hC3});
    ->kick;
    for (int n = 0; n < 1000 && msg_count !== 16'd4; n++) @(negedge clk);
    checks++; if (msg_count !== 16'd4) begin errors++; $display("FAIL rr_msg_count: got %0d expected 4", msg_count); end
    checks++; if (sent.size() != 8) begin errors++; $display("FAIL rr_byte_count: got %0d expected 8", sent.size()); end
    for (int i = 0; i < 8; i++) begin
      got = (i < sent.size()) ? sent[i] : ent_t'(12'h0);
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL rr_byte%0d: got g=%b d=%h expected g=%b d=%h", i, got.g, got.d, exp_q[i].g, exp_q[i].d); end
    end
  endtask

  task automatic test_forced_rotation();
    ent_t exp_q [7];
    ent_t got;
    exp_q = '{ {4'b0001, 8'hB0}, {4'b0001, 8'hB1}, {4'b0001, 8'hB2}, {4'b0001, 8'hB3},
               {4'b0010, 8'hD0}, {4'b0001, 8'hB4}, {4'b0001, 8'hB5} };
    apply_reset();
    busy_len = 3;
    for (int i = 0; i < 6; i++) rq[0].push_back({(i == 5) ? 1'b1 : 1'b0, 8'hB0 + 8'(i)});
    rq[1].push_back({1'b1, 8'hD0});
    ->kick;
    for (int n = 0; n < 1000 && msg_count !== 16'd2; n++) @(negedge clk);
    checks++; if (msg_count !== 16'd2) begin errors++; $display("FAIL rot_msg_count: got %0d expected 2", msg_count); end
    checks++; if (sent.size() != 7) begin errors++; $display("FAIL rot_byte_count: got %0d expected 7", sent.size()); end
    for (int i = 0; i < 7; i++) begin
      got = (i < sent.size()) ? sent[i] : ent_t'(12'h0);
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL rot_byte%0d: got g=%b d=%h expected g=%b d=%h", i, got.g, got.d, exp_q[i].g, exp_q[i].d); end
    end
  endtask

  task automatic test_stall_revocation();
    logic held_ok;
    ent_t got;
    apply_reset();
    busy_len = 3;
    rq[3].push_back({1'b0, 8'h5A});
    ->kick;
    for (int n = 0; n < 20 && grant !== 4'b1000; n++) @(negedge clk);
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL stall_grant3: got %b expected 1000", grant); end
    rq[0].push_back({1'b1, 8'hE0});
    ->kick;
    for (int n = 0; n < 100 && sent.size() == 0; n++) @(negedge clk);
    for (int n = 0; n < 100 && req_ready !== 4'b1000; n++) @(negedge clk);
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL stall_send_reentry: got %b expected 1000", req_ready); end
    held_ok = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (grant !== 4'b1000 || req_ready[0] !== 1'b0) held_ok = 1'b0;
    end
    checks++; if (held_ok !== 1'b1) begin errors++; $display("FAIL stall_hold_window: grant=%b held=%b expected held=1", grant, held_ok); end
    @(negedge clk);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL stall_revoke_s8: got %b expected 0000", grant); end
    checks++; if (msg_count !== 16'd0) begin errors++; $display("FAIL stall_msg_count: got %0d expected 0", msg_count); end
    @(negedge clk);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL stall_next_grant: got %b expected 0001", grant); end
    for (int n = 0; n < 200 && msg_count !== 16'd1; n++) @(negedge clk);
    got = (sent.size() >= 2) ? sent[1] : ent_t'(12'h0);
    checks++; if (got !== ent_t'({4'b0001, 8'hE0})) begin errors++; $display("FAIL stall_req0_byte: got g=%b d=%h expected g=0001 d=e0", got.g, got.d); end
  endtask

  task automatic test_ack_timeout();
    logic early;
    apply_reset();
    busy_len = 0;
    rq[2].push_back({1'b0, 8'hF0});
    rq[2].push_back({1'b1, 8'hF1});
    ->kick;
    for (int n = 0; n < 20 && uart_start !== 1'b1; n++) @(negedge clk);
    checks++; if (uart_start !== 1'b1 || uart_data !== 8'hF0) begin
      errors++; $display("FAIL ack_first_start: start=%b data=%h expected 1/f0", uart_start, uart_data);
    end
    early = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (req_ready !== 4'b0000) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL ack_early_release: got %b expected 0", early); end
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL ack_ready_a5: got %b expected 0100", req_ready); end
    @(negedge clk);
    checks++; if (uart_start !== 1'b1 || uart_data !== 8'hF1) begin
      errors++; $display("FAIL ack_second_start: start=%b data=%h expected 1/f1", uart_start, uart_data);
    end
    repeat (4) @(negedge clk);
    checks++; if (msg_count !== 16'd0) begin errors++; $display("FAIL ack_msg_early: got %0d expected 0", msg_count); end
    @(negedge clk);
    checks++; if (msg_count !== 16'd1 || grant !== 4'b0000) begin
      errors++; $display("FAIL ack_msg_done: msg=%0d grant=%b expected 1/0000", msg_count, grant);
    end
  endtask

  task automatic test_reset_mid_message();
    ent_t got;
    apply_reset();
    busy_len = 10;
    rq[2].push_back({1'b1, 8'h20});
    ->kick;
    for (int n = 0; n < 200 && msg_count !== 16'd1; n++) @(negedge clk);
    checks++; if (msg_count !== 16'd1) begin errors++; $display("FAIL rmid_first_msg: got %0d expected 1", msg_count); end
    rq[1].push_back({1'b0, 8'h31});
    rq[1].push_back({1'b0, 8'h32});
    rq[1].push_back({1'b1, 8'h33});
    ->kick;
    for (int n = 0; n < 300 && sent.size() < 3; n++) @(negedge clk);
    checks++; if (sent.size() != 3) begin errors++; $display("FAIL rmid_second_byte: got %0d bytes expected 3", sent.size()); end
    repeat (2) @(negedge clk);
    rq[1].delete();
    ->kick;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL rmid_grant: got %b expected 0000", grant); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rmid_ready: got %b expected 0000", req_ready); end
    checks++; if (uart_start !== 1'b0) begin errors++; $display("FAIL rmid_start: got %b expected 0", uart_start); end
    checks++; if (uart_data !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h expected 00", uart_data); end
    checks++; if (msg_count !== 16'd0) begin errors++; $display("FAIL rmid_msg_count: got %0d expected 0", msg_count); end
    rq[0].push_back({1'b1, 8'h40});
    rq[3].push_back({1'b1, 8'h43});
    ->kick;
    @(negedge clk);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rmid_ptr_cleared: got %b expected 0001", grant); end
    for (int n = 0; n < 300 && msg_count !== 16'd1; n++) @(negedge clk);
    got = (sent.size() != 0) ? sent[sent.size()-1] : ent_t'(12'h0);
    checks++; if (msg_count !== 16'd1 || got !== ent_t'({4'b0001, 8'h40})) begin
      errors++; $display("FAIL rmid_new_msg: msg=%0d g=%b d=%h expected 1/0001/40", msg_count, got.g, got.d);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_message();
    test_round_robin();
    test_forced_rotation();
    test_stall_revocation();
    test_ack_timeout();
    test_reset_mid_message();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
